mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports `clk` (in, 1, clock) and `reset` (in, 1, reset); one clock, reset synchronous and active-high.
REQ-002 SHALL have EX/MEM inputs, all in: `Ctl_MemtoReg_in`, `Ctl_RegWrite_in`, `Ctl_MemRead_in`, `Ctl_MemWrite_in`, `Ctl_Branch_in`, `jal_in`, `jalr_in`, `Zero_in` (1 each); `Rd_in` (5); `funct3_in` (3); `ALUresult_in`, `ReadData2_in`, `PCimm_in`, `PC_in` (32 each).
REQ-003 SHALL have a data-memory port: `dmem_req`, `dmem_we` (out, 1); `dmem_addr`, `dmem_wdata` (out, 32); `dmem_be` (out, 4); `dmem_ack` (in, 1); `dmem_rdata` (in, 32).
REQ-004 SHALL have control outputs: `stall` (out, 1, freeze IF/ID/EX); `PCSrc` (out, 1, redirect and flush); `PCtarget` (out, 32); `mem_fwd_data` (out, 32, forwarding value to EX); `misalign_err`, `bus_err` (out, 1, one-cycle pulses).
REQ-005 SHALL have MEM/WB registered outputs: `Ctl_MemtoReg_out`, `Ctl_RegWrite_out` (1); `Rd_out` (5); `ReadData_out`, `ALUresult_out` (32).

Function
REQ-006 SHALL have FSM states IDLE and WAIT. A mem op is `Ctl_MemRead_in | Ctl_MemWrite_in`.
REQ-007 SHALL flag misalignment when funct3[1:0]=01 and addr[0]=1, or funct3[1:0]=10 and addr[1:0]≠00. addr = `ALUresult_in`.
REQ-008 IDLE with an aligned mem op SHALL drive `dmem_req`=1 in the same cycle. If `dmem_ack`=1 that cycle, the op SHALL complete with no stall. Otherwise the FSM SHALL go to WAIT with `stall`=1.
REQ-009 WAIT SHALL hold `dmem_req`=1 and `stall`=1 until `dmem_ack`. On ack, the op SHALL complete, `stall`=0, next state IDLE. Upstream holds inputs stable while `stall`=1.
REQ-010 An 8-bit wait counter SHALL clear on entering WAIT and increment each WAIT cycle without ack. On reaching 255: abort, pulse `bus_err`, bubble MEM/WB, return to IDLE, `stall`=0.
REQ-011 A misaligned mem op SHALL issue no request, pulse `misalign_err`, bubble MEM/WB and not stall.
REQ-012 Stores SHALL drive `dmem_we`=1 with byte enables:
 - sb: `dmem_be`=0001<<addr[1:0], `dmem_wdata`={4{ReadData2_in[7:0]}}
 - sh: `dmem_be`=0011<<addr[1:0], `dmem_wdata`={2{ReadData2_in[15:0]}}
 - sw: `dmem_be`=1111, `dmem_wdata`=ReadData2_in
REQ-013 Loads SHALL drive `dmem_be` per REQ-012 and `dmem_we`=0. On completion, `ReadData_out` SHALL take the lane selected by addr:
 - funct3 000 lb, 001 lh: sign-extended
 - 100 lbu, 101 lhu: zero-extended
 - 010 lw: full word
REQ-014 `dmem_addr` SHALL equal {addr[31:2],2'b00}. `dmem_req`, `dmem_we` and `dmem_be` SHALL be 0 when no request is issued.
REQ-015 Branch taken SHALL be `Ctl_Branch_in & (funct3_in==001 ? ~Zero_in : Zero_in)`.
REQ-016 `PCSrc` SHALL be (branch taken | `jal_in` | `jalr_in`) & ~`reset`, combinational.
REQ-017 `PCtarget` SHALL be `ALUresult_in` & ~1 when `jalr_in`=1, else `PCimm_in`.
REQ-018 `mem_fwd_data` SHALL be `PC_in`+4 when `jal_in|jalr_in`, else `ALUresult_in`.
REQ-019 Each cycle without stall or abort, MEM/WB SHALL load:
 - control bits and `Rd_in`
 - `ALUresult_out` = `mem_fwd_data`
 - `ReadData_out` = load data, or 0 for non-loads
REQ-020 Each stall cycle SHALL load a bubble: `Ctl_RegWrite_out`=0, `Ctl_MemtoReg_out`=0, `Rd_out`=0; data outputs hold.

Reset
REQ-021 With `reset`=1 at an edge, the block SHALL set:
 - state IDLE, counter 0
 - all MEM/WB outputs 0
 - `misalign_err`=0, `bus_err`=0
REQ-022 In any cycle with `reset`=1, `dmem_req`, `stall` and `PCSrc` SHALL be 0. Reset in WAIT SHALL abandon the op with no err pulse.

Verification
REQ-023 Bench SHALL cover these directed scenarios:
 - lw, addr 0x100, ack same cycle, rdata 0xDEADBEEF -> `stall` never 1; next edge `ReadData_out`=0xDEADBEEF, `Ctl_RegWrite_out`=1.
 - lb, addr 0x103, ack after 3 cycles, rdata 0x80000000 -> `stall`=1 for 3 cycles, 3 bubbles; then `ReadData_out`=0xFFFFFF80.
 - sh, addr 0x102, ReadData2 0x1234ABCD -> `dmem_be`=1100, `dmem_wdata`=0xABCDABCD, `dmem_we`=1.
 - lw, addr 0x101 -> `dmem_req`=0, `misalign_err` pulse, `Ctl_RegWrite_out`=0.
 - bne with Zero_in=0, PCimm 0x40 -> `PCSrc`=1, `PCtarget`=0x40. jalr with ALUresult 0x201, PC 0x10 -> `PCtarget`=0x200, `ALUresult_out`=0x14.
 - no ack for 255 WAIT cycles -> `bus_err` pulse, `stall` drops, FSM in IDLE. Separate run: reset in WAIT -> `dmem_req`=0 same cycle, IDLE next.

Source files
------------

// File: rtl/mem_access_if.sv
// Data-memory request/response bus between the MEM stage and the memory.
// The memory either acknowledges in the same cycle or holds off, and the MEM stage keeps waiting.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: data-memory access with wait states and timeout, branch/jump resolution,
// and the MEM/WB pipeline register.
module mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        Ctl_MemtoReg_in,
  input  logic        Ctl_RegWrite_in,
  input  logic        Ctl_MemRead_in,
  input  logic        Ctl_MemWrite_in,
  input  logic        Ctl_Branch_in,
  input  logic        jal_in,
  input  logic        jalr_in,
  input  logic        Zero_in,
  input  logic [4:0]  Rd_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] ALUresult_in,
  input  logic [31:0] ReadData2_in,
  input  logic [31:0] PCimm_in,
  input  logic [31:0] PC_in,
  mem_access_if.master dmem,
  output logic        stall,
  output logic        PCSrc,
  output logic [31:0] PCtarget,
  output logic [31:0] mem_fwd_data,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        Ctl_MemtoReg_out,
  output logic        Ctl_RegWrite_out,
  output logic [4:0]  Rd_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUresult_out
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        misalign_err_q, bus_err_q;
  logic        memtoreg_q, regwrite_q;
  logic [4:0]  rd_q;
  logic [31:0] rdata_q, alures_q;

  logic        mem_op, misalign, issue, misalign_op, timeout;
  logic        req, abort, load_wb, branch_taken;
  logic [1:0]  off;

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] o);
    unique case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << o;
      2'b01:   byte_en = 4'b0011 << o;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    unique case (f3[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend by access size and signedness.
  function automatic logic [31:0] load_data(input logic [2:0] f3, input logic [1:0] o,
                                            input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> {o, 3'b000};
    unique case (f3)
      3'b000:  load_data = {{24{s[7]}}, s[7:0]};
      3'b001:  load_data = {{16{s[15]}}, s[15:0]};
      3'b100:  load_data = {24'b0, s[7:0]};
      3'b101:  load_data = {16'b0, s[15:0]};
      default: load_data = rd;
    endcase
  endfunction

  assign off         = ALUresult_in[1:0];
  assign mem_op      = Ctl_MemRead_in | Ctl_MemWrite_in;
  assign misalign    = ((funct3_in[1:0] == 2'b01) && off[0]) ||
                       ((funct3_in[1:0] == 2'b10) && (off != 2'b00));
  assign issue       = mem_op & ~misalign;
  assign misalign_op = (state_q == S_IDLE) & mem_op & misalign & ~reset;
  assign timeout     = (state_q == S_WAIT) & ~dmem.dmem_ack & (cnt_q == 8'hFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (issue && !dmem.dmem_ack) begin
        state_d = S_WAIT;
        cnt_d   = 8'd0;
      end
      S_WAIT: begin
        if (dmem.dmem_ack || timeout) state_d = S_IDLE;
        else                          cnt_d   = cnt_q + 8'd1;
      end
    endcase
  end

  // Reset overrides every request/stall decision so an in-flight access is dropped silently.
  always_comb begin
    req   = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
    unique case (state_q)
      S_IDLE: if (issue) begin
        req   = 1'b1;
        stall = ~dmem.dmem_ack;
      end
      S_WAIT: begin
        req   = 1'b1;
        abort = timeout;
        stall = ~dmem.dmem_ack & ~timeout;
      end
    endcase
    if (reset) begin
      req   = 1'b0;
      stall = 1'b0;
      abort = 1'b0;
    end
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & Ctl_MemWrite_in;
  assign dmem.dmem_be    = req ? byte_en(funct3_in, off) : 4'b0000;
  assign dmem.dmem_addr  = {ALUresult_in[31:2], 2'b00};
  assign dmem.dmem_wdata = store_data(funct3_in, ReadData2_in);

  assign branch_taken = Ctl_Branch_in & ((funct3_in == 3'b001) ? ~Zero_in : Zero_in);
  assign PCSrc        = (branch_taken | jal_in | jalr_in) & ~reset;
  assign PCtarget     = jalr_in ? {ALUresult_in[31:1], 1'b0} : PCimm_in;
  assign mem_fwd_data = (jal_in | jalr_in) ? (PC_in + 32'd4) : ALUresult_in;

  assign load_wb = ~stall & ~abort & ~misalign_op;

  // MEM/WB boundary: stalls, aborts and misaligned ops insert a bubble while data holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      memtoreg_q     <= 1'b0;
      regwrite_q     <= 1'b0;
      rd_q           <= 5'd0;
      rdata_q        <= 32'd0;
      alures_q       <= 32'd0;
      misalign_err_q <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      misalign_err_q <= misalign_op;
      bus_err_q      <= abort;
      if (load_wb) begin
        memtoreg_q <= Ctl_MemtoReg_in;
        regwrite_q <= Ctl_RegWrite_in;
        rd_q       <= Rd_in;
        alures_q   <= mem_fwd_data;
        rdata_q    <= Ctl_MemRead_in ? load_data(funct3_in, off, dmem.dmem_rdata) : 32'd0;
      end else begin
        memtoreg_q <= 1'b0;
        regwrite_q <= 1'b0;
        rd_q       <= 5'd0;
      end
    end
  end

  assign misalign_err     = misalign_err_q;
  assign bus_err          = bus_err_q;
  assign Ctl_MemtoReg_out = memtoreg_q;
  assign Ctl_RegWrite_out = regwrite_q;
  assign Rd_out           = rd_q;
  assign ReadData_out     = rdata_q;
  assign ALUresult_out    = alures_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads/stores, wait states, timeout, misalignment,
// branch/jump resolution and reset behaviour.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        reset;
  logic        MemtoReg, RegWrite, MemRead, MemWrite, Branch, jal, jalr, Zero;
  logic [4:0]  Rd;
  logic [2:0]  funct3;
  logic [31:0] ALUres, RD2, PCimm, PC;
  logic        stall, PCSrc, misalign_err, bus_err, MemtoReg_o, RegWrite_o;
  logic [31:0] PCtarget, mem_fwd_data, ReadData_o, ALUres_o;
  logic [4:0]  Rd_o;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_stall;

  mem_access_if bus ();

  mem_access dut (
    .clk(clk), .reset(reset),
    .Ctl_MemtoReg_in(MemtoReg), .Ctl_RegWrite_in(RegWrite), .Ctl_MemRead_in(MemRead),
    .Ctl_MemWrite_in(MemWrite), .Ctl_Branch_in(Branch), .jal_in(jal), .jalr_in(jalr),
    .Zero_in(Zero), .Rd_in(Rd), .funct3_in(funct3), .ALUresult_in(ALUres),
    .ReadData2_in(RD2), .PCimm_in(PCimm), .PC_in(PC),
    .dmem(bus),
    .stall(stall), .PCSrc(PCSrc), .PCtarget(PCtarget), .mem_fwd_data(mem_fwd_data),
    .misalign_err(misalign_err), .bus_err(bus_err),
    .Ctl_MemtoReg_out(MemtoReg_o), .Ctl_RegWrite_out(RegWrite_o), .Rd_out(Rd_o),
    .ReadData_out(ReadData_o), .ALUresult_out(ALUres_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    MemtoReg = 0; RegWrite = 0; MemRead = 0; MemWrite = 0; Branch = 0;
    jal = 0; jalr = 0; Zero = 0; Rd = 0; funct3 = 0;
    ALUres = 0; RD2 = 0; PCimm = 0; PC = 0;
    bus.dmem_ack = 0; bus.dmem_rdata = 0;
  endtask

  initial begin
    clear_in();
    reset = 1;
    // Reset: combinational outputs gated even with a jump and mem op present
    jal = 1; MemRead = 1; funct3 = 3'b010; ALUres = 32'h100;
    #1;
    chk("rst_pcsrc", PCSrc, 0);
    chk("rst_req", bus.dmem_req, 0);
    chk("rst_stall", stall, 0);
    tick(); tick();
    chk("rst_regwrite", RegWrite_o, 0);
    chk("rst_rd", Rd_o, 0);
    chk("rst_rdata", ReadData_o, 0);
    chk("rst_alures", ALUres_o, 0);
    chk("rst_errs", {misalign_err, bus_err}, 0);

    // lw 0x100 with same-cycle ack
    reset = 0; clear_in();
    MemRead = 1; MemtoReg = 1; RegWrite = 1; Rd = 5; funct3 = 3'b010; ALUres = 32'h100;
    bus.dmem_ack = 1; bus.dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_req", bus.dmem_req, 1);
    chk("lw_stall", stall, 0);
    chk("lw_we", bus.dmem_we, 0);
    chk("lw_be", bus.dmem_be, 4'b1111);
    chk("lw_addr", bus.dmem_addr, 32'h100);
    tick();
    chk("lw_rdata", ReadData_o, 32'hDEADBEEF);
    chk("lw_regwrite", RegWrite_o, 1);
    chk("lw_rd", Rd_o, 5);
    chk("lw_alures", ALUres_o, 32'h100);

    // lb 0x103, ack arrives after 3 stall cycles
    clear_in();
    MemRead = 1; MemtoReg = 1; RegWrite = 1; Rd = 7; funct3 = 3'b000; ALUres = 32'h103;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lb_stall", stall, 1);
      chk("lb_req", bus.dmem_req, 1);
      chk("lb_be", bus.dmem_be, 4'b1000);
      tick();
      chk("lb_bubble_rw", RegWrite_o, 0);
      chk("lb_bubble_rd", Rd_o, 0);
      chk("lb_hold_data", ReadData_o, 32'hDEADBEEF);
    end
    bus.dmem_ack = 1; bus.dmem_rdata = 32'h80000000;
    #1;
    chk("lb_ack_stall", stall, 0);
    tick();
    chk("lb_rdata", ReadData_o, 32'hFFFFFF80);
    chk("lb_regwrite", RegWrite_o, 1);
    chk("lb_rd", Rd_o, 7);

    // lhu 0x102 and lbu 0x101: zero extension of upper lanes
    clear_in();
    MemRead = 1; RegWrite = 1; Rd = 2; funct3 = 3'b101; ALUres = 32'h102;
    bus.dmem_ack = 1; bus.dmem_rdata = 32'h8001_7F00;
    tick();
    chk("lhu_rdata", ReadData_o, 32'h0000_8001);
    funct3 = 3'b100; ALUres = 32'h101; bus.dmem_rdata = 32'h0000_F100;
    tick();
    chk("lbu_rdata", ReadData_o, 32'h0000_00F1);

    // sh 0x102
    clear_in();
    MemWrite = 1; funct3 = 3'b001; ALUres = 32'h102; RD2 = 32'h1234ABCD; bus.dmem_ack = 1;
    #1;
    chk("sh_be", bus.dmem_be, 4'b1100);
    chk("sh_wdata", bus.dmem_wdata, 32'hABCDABCD);
    chk("sh_we", bus.dmem_we, 1);
    chk("sh_addr", bus.dmem_addr, 32'h100);
    tick();
    chk("sh_rdata_zero", ReadData_o, 0);
    chk("sh_regwrite", RegWrite_o, 0);

    // sb 0x101
    funct3 = 3'b000; ALUres = 32'h101; RD2 = 32'h0000_0055;
    #1;
    chk("sb_be", bus.dmem_be, 4'b0010);
    chk("sb_wdata", bus.dmem_wdata, 32'h55555555);
    tick();

    // Misaligned lw 0x101
    clear_in();
    MemRead = 1; RegWrite = 1; Rd = 9; funct3 = 3'b010; ALUres = 32'h101;
    #1;
    chk("mis_req", bus.dmem_req, 0);
    chk("mis_be", bus.dmem_be, 0);
    chk("mis_stall", stall, 0);
    tick();
    chk("mis_err", misalign_err, 1);
    chk("mis_regwrite", RegWrite_o, 0);
    clear_in();
    tick();
    chk("mis_err_pulse", misalign_err, 0);

    // bne taken, beq not taken, jalr
    Branch = 1; funct3 = 3'b001; Zero = 0; PCimm = 32'h40; ALUres = 32'h77;
    #1;
    chk("bne_pcsrc", PCSrc, 1);
    chk("bne_target", PCtarget, 32'h40);
    funct3 = 3'b000;
    #1;
    chk("beq_pcsrc", PCSrc, 0);
    clear_in();
    jalr = 1; ALUres = 32'h201; PC = 32'h10; PCimm = 32'h999; RegWrite = 1; Rd = 1;
    #1;
    chk("jalr_pcsrc", PCSrc, 1);
    chk("jalr_target", PCtarget, 32'h200);
    chk("jalr_fwd", mem_fwd_data, 32'h14);
    tick();
    chk("jalr_alures", ALUres_o, 32'h14);
    chk("jalr_regwrite", RegWrite_o, 1);

    // Timeout: no ack ever; 1 IDLE stall + 255 counting WAIT cycles, then abort
    clear_in();
    MemRead = 1; RegWrite = 1; Rd = 3; funct3 = 3'b010; ALUres = 32'h200;
    n_stall = 0;
    #1;
    for (int i = 0; i < 400; i++) begin
      if (!stall) break;
      n_stall++;
      tick();
    end
    chk("tmo_stall_cycles", n_stall, 256);
    chk("tmo_stall_drop", stall, 0);
    tick();
    chk("tmo_bus_err", bus_err, 1);
    chk("tmo_bubble", RegWrite_o, 0);
    bus.dmem_ack = 1; bus.dmem_rdata = 32'h0BAD_F00D;
    #1;
    chk("tmo_idle_nostall", stall, 0);
    tick();
    chk("tmo_err_pulse", bus_err, 0);
    chk("tmo_next_rdata", ReadData_o, 32'h0BAD_F00D);

    // Reset while in WAIT
    clear_in();
    MemRead = 1; RegWrite = 1; Rd = 4; funct3 = 3'b010; ALUres = 32'h300;
    #1;
    chk("rw_stall0", stall, 1);
    tick();
    chk("rw_stall1", stall, 1);
    reset = 1;
    #1;
    chk("rw_req", bus.dmem_req, 0);
    chk("rw_stall", stall, 0);
    tick();
    reset = 0; clear_in();
    #1;
    chk("rw_idle_req", bus.dmem_req, 0);
    chk("rw_idle_stall", stall, 0);
    tick();
    chk("rw_no_err", {misalign_err, bus_err}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
